// File: rtl/hps_batch_dispatcher.sv
// hps_batch_dispatcher: polls an SRAM mailbox, dispatches (x,y,val) entries to column
// units over req/ack with range checks and timeout, then writes status and clears the flag.
module hps_batch_dispatcher #(
  parameter int ADDR_W   = 8,
  parameter int NUM_COLS = 100,
  parameter int NUM_ROWS = 480,
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int VAL_W    = 8,
  parameter int READ_LAT = 2,
  parameter int TIMEOUT  = 1023
) (
  input  logic                clock,
  input  logic                reset,
  output logic [ADDR_W-1:0]   sram_address,
  output logic                sram_write,
  output logic [31:0]         sram_writedata,
  input  logic [31:0]         sram_readdata,
  output logic [NUM_COLS-1:0] col_select,
  output logic [Y_W-1:0]      row_select,
  output logic [VAL_W-1:0]    val_out,
  input  logic [NUM_COLS-1:0] return_sig,
  output logic                busy,
  output logic                batch_done
);
  localparam int LW = READ_LAT > 1 ? $clog2(READ_LAT) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] MAX_ENT = (ADDR_W+1)'((1 << ADDR_W) - 3);
  typedef enum logic [3:0] {
    IDLE, WAIT_F, CHECK_F, RD_CNT, WAIT_C, RD_ENT, WAIT_E, CHECK_E, DISPATCH, NEXT, WR_STAT, WR_CLR
  } state_t;
  state_t state, state_n;
  logic [LW-1:0] wcnt, wcnt_n;
  logic [31:0] rdat, rdat_n;
  logic [ADDR_W-1:0] n, n_n, idx, idx_n, addr_n;
  logic [TW-1:0] timer, timer_n;
  logic [15:0] c_done, c_done_n;
  logic [7:0] c_rerr, c_rerr_n, c_to, c_to_n;
  logic [NUM_COLS-1:0] col_n;
  logic [Y_W-1:0] row_n;
  logic [VAL_W-1:0] val_n;
  logic busy_n, rd_last;
  logic [X_W-1:0] ex;
  logic [Y_W-1:0] ey;
  logic [VAL_W-1:0] ev;
  logic [ADDR_W:0] raw_n;
  logic [ADDR_W-1:0] cnt_n;
  assign ex = rdat[20 +: X_W];
  assign ey = rdat[8 +: Y_W];
  assign ev = rdat[0 +: VAL_W];
  assign rd_last = wcnt == LW'(READ_LAT - 1);
  assign raw_n = sram_readdata[ADDR_W:0];
  assign cnt_n = raw_n > MAX_ENT ? MAX_ENT[ADDR_W-1:0] : raw_n[ADDR_W-1:0];
  always_comb begin
    state_n = state;
    wcnt_n = '0;
    rdat_n = rdat;
    n_n = n;
    idx_n = idx;
    timer_n = timer;
    c_done_n = c_done;
    c_rerr_n = c_rerr;
    c_to_n = c_to;
    col_n = col_select;
    row_n = row_select;
    val_n = val_out;
    busy_n = busy;
    case (state)
      IDLE: state_n = WAIT_F;
      WAIT_F, WAIT_C, WAIT_E: begin
        wcnt_n = rd_last ? '0 : wcnt + LW'(1);
        rdat_n = rd_last ? sram_readdata : rdat;
        n_n = (rd_last && state == WAIT_C) ? cnt_n : n;
        if (rd_last)
          state_n = state == WAIT_F ? CHECK_F : state == WAIT_E ? CHECK_E :
                    cnt_n == '0 ? WR_STAT : RD_ENT;
      end
      CHECK_F: begin
        state_n = rdat == '0 ? IDLE : RD_CNT;
        busy_n = rdat != '0;
        c_done_n = '0;
        c_rerr_n = '0;
        c_to_n = '0;
      end
      RD_CNT: begin
        state_n = WAIT_C;
        idx_n = '0;
      end
      RD_ENT: state_n = WAIT_E;
      CHECK_E: begin
        if (32'(ex) >= NUM_COLS || 32'(ey) >= NUM_ROWS) begin
          c_rerr_n = c_rerr + 8'(c_rerr != '1);
          state_n = NEXT;
        end else begin
          col_n = NUM_COLS'(1) << ex;
          row_n = ey;
          val_n = ev;
          timer_n = '0;
          state_n = DISPATCH;
        end
      end
      DISPATCH: begin
        // only the selected column's acknowledge can match
        if ((return_sig & col_select) != '0) begin
          col_n = '0;
          c_done_n = c_done + 16'(c_done != '1);
          state_n = NEXT;
        end else if (timer == TW'(TIMEOUT)) begin
          col_n = '0;
          c_to_n = c_to + 8'(c_to != '1);
          state_n = NEXT;
        end else timer_n = timer + TW'(1);
      end
      NEXT: begin
        idx_n = idx + ADDR_W'(1);
        state_n = idx + ADDR_W'(1) == n ? WR_STAT : RD_ENT;
      end
      WR_STAT: state_n = WR_CLR;
      WR_CLR: begin
        busy_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    addr_n = state_n == WAIT_C ? ADDR_W'(1) :
             state_n == WAIT_E ? idx + ADDR_W'(2) :
             state_n == WR_STAT ? '1 :
             (state_n == WAIT_F || state_n == WR_CLR) ? '0 : sram_address;
  end
  // all outputs are registered from the next state so they line up with the state they belong to
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      wcnt <= '0;
      rdat <= '0;
      n <= '0;
      idx <= '0;
      timer <= '0;
      c_done <= '0;
      c_rerr <= '0;
      c_to <= '0;
      sram_address <= '0;
      sram_write <= 1'b0;
      sram_writedata <= '0;
      col_select <= '0;
      row_select <= '0;
      val_out <= '0;
      busy <= 1'b0;
      batch_done <= 1'b0;
    end else begin
      state <= state_n;
      wcnt <= wcnt_n;
      rdat <= rdat_n;
      n <= n_n;
      idx <= idx_n;
      timer <= timer_n;
      c_done <= c_done_n;
      c_rerr <= c_rerr_n;
      c_to <= c_to_n;
      sram_address <= addr_n;
      sram_write <= state_n == WR_STAT || state_n == WR_CLR;
      sram_writedata <= state_n == WR_STAT ? {c_to, c_rerr, c_done} : '0;
      col_select <= col_n;
      row_select <= row_n;
      val_out <= val_n;
      busy <= busy_n;
      batch_done <= state_n == WR_CLR;
    end
  end
endmodule

// File: tb/tb_hps_batch_dispatcher.sv
// tb_hps_batch_dispatcher: directed scenarios against a latency-2 SRAM model and an
// echoing column-unit model, with hand-computed expectations.
module tb_hps_batch_dispatcher;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [7:0] sram_address;
  logic sram_write;
  logic [31:0] sram_writedata;
  logic [31:0] sram_readdata = '0;
  logic [99:0] col_select;
  logic [9:0] row_select;
  logic [7:0] val_out;
  logic [99:0] return_sig;
  logic busy, batch_done;
  logic [31:0] mem [256] = '{default: 32'h0};
  logic h_we = 1'b0;
  logic [7:0] h_a = '0;
  logic [31:0] h_d = '0;
  logic echo = 1'b0;
  logic [99:0] rs1 = '0, rs2 = '0, prev_col = '0;
  logic [9:0] prev_row = '0;
  logic [7:0] prev_val = '0;
  int cyc = 0, nw = 0, np = 0, bd_cnt = 0;
  int w_a [64], w_d [64], w_cyc [64];
  int p_idx [64], p_row [64], p_val [64], p_w [64], p_cyc [64];
  logic onehot_bad = 1'b0, stable_bad = 1'b0, bad255 = 1'b0;
  int total = 0, bad = 0;

  hps_batch_dispatcher #(
    .ADDR_W(8), .NUM_COLS(100), .NUM_ROWS(480), .X_W(10), .Y_W(10), .VAL_W(8),
    .READ_LAT(2), .TIMEOUT(15)
  ) dut (
    .clock(clock), .reset(reset), .sram_address(sram_address), .sram_write(sram_write),
    .sram_writedata(sram_writedata), .sram_readdata(sram_readdata), .col_select(col_select),
    .row_select(row_select), .val_out(val_out), .return_sig(return_sig), .busy(busy),
    .batch_done(batch_done)
  );

  always #5 clock = ~clock;
  assign return_sig = echo ? rs2 : '0;

  function automatic int oh_idx(input logic [99:0] v);
    for (int i = 0; i < 100; i++) if (v[i]) return i;
    return -1;
  endfunction

  // SRAM: one register stage after the address register gives a 2-cycle read latency
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (sram_write) begin
      mem[sram_address] <= sram_writedata;
      if (nw < 64) begin
        w_a[nw] <= int'(sram_address);
        w_d[nw] <= int'(sram_writedata);
        w_cyc[nw] <= cyc;
      end
      nw <= nw + 1;
    end else if (h_we) mem[h_a] <= h_d;
    if (sram_address == 8'hFF && !sram_write) bad255 <= 1'b1;
    sram_readdata <= mem[sram_address];
    rs1 <= col_select;
    rs2 <= rs1;
  end

  always @(negedge clock) begin
    if (col_select != '0) begin
      if ($countones(col_select) != 1) onehot_bad <= 1'b1;
      if (prev_col == '0) begin
        if (np < 64) begin
          p_idx[np] <= oh_idx(col_select);
          p_row[np] <= int'(row_select);
          p_val[np] <= int'(val_out);
          p_w[np] <= 1;
          p_cyc[np] <= cyc;
        end
        np <= np + 1;
      end else begin
        if (np > 0 && np <= 64) p_w[np-1] <= p_w[np-1] + 1;
        if (col_select != prev_col || row_select != prev_row || val_out != prev_val) stable_bad <= 1'b1;
      end
    end
    if (batch_done) bd_cnt <= bd_cnt + 1;
    prev_col <= col_select;
    prev_row <= row_select;
    prev_val <= val_out;
  end

  task automatic host_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clock);
    h_we = 1'b1;
    h_a = a;
    h_d = d;
    @(negedge clock);
    h_we = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int b;
    int i;
    b = bd_cnt;
    i = 0;
    while (bd_cnt == b && i < budget) begin
      @(negedge clock);
      i++;
    end
    if (bd_cnt == b) begin
      total++;
      bad++;
      $display("FAIL %s: no batch_done within %0d cycles", name, budget);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    total++;
    if ({sram_address, sram_write, sram_writedata, col_select, row_select, val_out, busy, batch_done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: addr=%0h wr=%b col=%h busy=%b required all zero", sram_address, sram_write, col_select, busy);
    end
    reset = 1'b1;
  endtask

  task automatic test_idle();
    int b, anomalies;
    b = nw;
    anomalies = 0;
    repeat (40) begin
      @(negedge clock);
      if (busy || batch_done || col_select != '0 || sram_address != 8'h00) anomalies++;
    end
    total++;
    if (anomalies !== 0) begin
      bad++;
      $display("FAIL idle_quiet: %0d active cycles, required 0", anomalies);
    end
    total++;
    if (nw - b !== 0) begin
      bad++;
      $display("FAIL idle_writes: %0d writes, required 0", nw - b);
    end
  endtask

  task automatic test_basic();
    int bp, bw, bb;
    int ei [3] = '{5, 99, 0};
    int er [3] = '{10, 479, 0};
    int ev [3] = '{'h7F, 'h80, 'h01};
    bp = np;
    bw = nw;
    bb = bd_cnt;
    echo = 1'b1;
    host_wr(8'd1, 32'd3);
    host_wr(8'd2, 32'h0050_0A7F);
    host_wr(8'd3, 32'h0631_DF80);
    host_wr(8'd4, 32'h0000_0001);
    host_wr(8'd0, 32'd1);
    wait_done(400, "basic_done");
    total++;
    if (np - bp !== 3) begin
      bad++;
      $display("FAIL basic_pulses: got %0d col pulses, required 3", np - bp);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (p_idx[bp+k] !== ei[k] || p_row[bp+k] !== er[k] || p_val[bp+k] !== ev[k] || p_w[bp+k] !== 3) begin
        bad++;
        $display("FAIL basic_entry%0d: col=%0d row=%0d val=%0h width=%0d required col=%0d row=%0d val=%0h width=3",
                 k, p_idx[bp+k], p_row[bp+k], p_val[bp+k], p_w[bp+k], ei[k], er[k], ev[k]);
      end
    end
    total++;
    if (p_cyc[bp+1] - p_cyc[bp] !== 8) begin
      bad++;
      $display("FAIL basic_spacing: %0d cycles between dispatches, required 8", p_cyc[bp+1] - p_cyc[bp]);
    end
    total++;
    if (nw - bw !== 2) begin
      bad++;
      $display("FAIL basic_nwrites: %0d writes, required 2", nw - bw);
    end
    total++;
    if (w_a[bw] !== 255 || w_d[bw] !== 32'h0000_0003) begin
      bad++;
      $display("FAIL basic_status: addr=%0d data=%08h required addr=255 data=00000003", w_a[bw], w_d[bw]);
    end
    total++;
    if (w_a[bw+1] !== 0 || w_d[bw+1] !== 0 || w_cyc[bw+1] !== w_cyc[bw] + 1) begin
      bad++;
      $display("FAIL basic_clear: addr=%0d data=%0h gap=%0d required addr=0 data=0 gap=1",
               w_a[bw+1], w_d[bw+1], w_cyc[bw+1] - w_cyc[bw]);
    end
    total++;
    if (bd_cnt - bb !== 1) begin
      bad++;
      $display("FAIL basic_batch_done: %0d pulses, required 1", bd_cnt - bb);
    end
    total++;
    if (onehot_bad !== 1'b0 || stable_bad !== 1'b0) begin
      bad++;
      $display("FAIL basic_onehot_stable: onehot_bad=%b stable_bad=%b required 0 0", onehot_bad, stable_bad);
    end
  endtask

  task automatic test_range();
    int bp, bw;
    bp = np;
    bw = nw;
    host_wr(8'd1, 32'd2);
    host_wr(8'd2, 32'h0640_0000);
    host_wr(8'd3, 32'h0001_E000);
    host_wr(8'd0, 32'd1);
    wait_done(300, "range_done");
    total++;
    if (np - bp !== 0) begin
      bad++;
      $display("FAIL range_no_select: %0d col pulses, required 0", np - bp);
    end
    total++;
    if (w_a[bw] !== 255 || w_d[bw] !== 32'h0002_0000) begin
      bad++;
      $display("FAIL range_status: addr=%0d data=%08h required addr=255 data=00020000", w_a[bw], w_d[bw]);
    end
  endtask

  task automatic test_timeout();
    int bp, bw;
    bp = np;
    bw = nw;
    echo = 1'b0;
    host_wr(8'd1, 32'd1);
    host_wr(8'd2, 32'h0070_0309);
    host_wr(8'd0, 32'd1);
    wait_done(300, "timeout_done");
    total++;
    if (np - bp !== 1 || p_idx[bp] !== 7 || p_w[bp] !== 16 || p_row[bp] !== 3 || p_val[bp] !== 9) begin
      bad++;
      $display("FAIL timeout_select: pulses=%0d col=%0d width=%0d row=%0d val=%0d required 1 7 16 3 9",
               np - bp, p_idx[bp], p_w[bp], p_row[bp], p_val[bp]);
    end
    total++;
    if (w_d[bw] !== 32'h0100_0000) begin
      bad++;
      $display("FAIL timeout_status: data=%08h required 01000000", w_d[bw]);
    end
  endtask

  task automatic test_clamp();
    int bw;
    bw = nw;
    for (int a = 2; a < 255; a++) host_wr(8'(a), 32'h0640_0000);
    host_wr(8'd255, 32'h0050_0A7F);
    host_wr(8'd1, 32'h0000_01FF);
    host_wr(8'd0, 32'd1);
    wait_done(3000, "clamp_done");
    total++;
    if (nw - bw !== 2 || w_a[bw] !== 255 || w_d[bw] !== 32'h00FD_0000) begin
      bad++;
      $display("FAIL clamp_status: writes=%0d addr=%0d data=%08h required 2 255 00FD0000", nw - bw, w_a[bw], w_d[bw]);
    end
    total++;
    if (bad255 !== 1'b0) begin
      bad++;
      $display("FAIL clamp_addr255_read: read of status word seen=%b required 0", bad255);
    end
  endtask

  task automatic test_reset_mid();
    int bp, bw, bb, i;
    bp = np;
    bw = nw;
    bb = bd_cnt;
    echo = 1'b0;
    host_wr(8'd1, 32'd1);
    host_wr(8'd2, 32'h0070_0309);
    host_wr(8'd0, 32'd1);
    i = 0;
    while (col_select == '0 && i < 200) begin
      @(negedge clock);
      i++;
    end
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({sram_address, sram_write, sram_writedata, col_select, row_select, val_out, busy, batch_done} !== '0) begin
      bad++;
      $display("FAIL midreset_async: col=%h busy=%b row=%0d val=%0d required all zero", col_select, busy, row_select, val_out);
    end
    echo = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    wait_done(300, "midreset_done");
    total++;
    if (np - bp !== 2 || p_idx[bp] !== 7 || p_idx[bp+1] !== 7 || p_w[bp+1] !== 3) begin
      bad++;
      $display("FAIL midreset_redispatch: pulses=%0d first=%0d second=%0d width=%0d required 2 7 7 3",
               np - bp, p_idx[bp], p_idx[bp+1], p_w[bp+1]);
    end
    total++;
    if (nw - bw !== 2 || w_a[bw] !== 255 || w_d[bw] !== 32'h0000_0001) begin
      bad++;
      $display("FAIL midreset_status: writes=%0d addr=%0d data=%08h required 2 255 00000001", nw - bw, w_a[bw], w_d[bw]);
    end
    total++;
    if (bd_cnt - bb !== 1) begin
      bad++;
      $display("FAIL midreset_batch_done: %0d pulses, required 1", bd_cnt - bb);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic();
    test_range();
    test_timeout();
    test_clamp();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
